// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;
  localparam int XLEN          = 64;
  localparam int ILEN          = 32;
  localparam int COMMIT_INFO_W = 1 + ILEN + 2 * XLEN;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, instr} entries; flush has priority over push/pop.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push && (cnt_q != FULL);
    do_pop  = pop && (cnt_q != '0);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, small fetch buffer.
// FETCH_CTRL_COMMIT_INFO_EN adds the out_commit_info bundle port.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pre_pc
`ifdef FETCH_CTRL_COMMIT_INFO_EN
  ,
  output logic [COMMIT_INFO_W-1:0] out_commit_info
`endif
);
  localparam int              CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            buf_push, buf_pop, buf_flush, req_fire;
  fetch_entry_t    buf_head, push_entry;
  logic [CW-1:0]   buf_cnt;
  logic            unused_redir_lo;

  assign unused_redir_lo = ^redirect_pc[1:0];

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    buf_push       = 1'b0;
    buf_flush      = redirect_valid;
    // Only one request in flight, so a free slot now is still free when it returns.
    imem_req_valid = rst && (state_q == ST_REQ) && (buf_cnt < DEPTH_C) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          buf_push = !redirect_valid;
          state_d  = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign push_entry    = '{pc: req_pc_q, instr: imem_resp_data};
  assign imem_req_addr = pc_q;
  assign buf_pop       = out_valid && out_ready;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_entry(push_entry),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .head      (buf_head),
    .count     (buf_cnt)
  );

  // Head fields are zeroed when the buffer is empty so decode never sees stale entries.
  assign out_valid  = (buf_cnt != '0);
  assign out_pc     = out_valid ? buf_head.pc : '0;
  assign out_instr  = out_valid ? buf_head.instr : '0;
  assign out_pre_pc = out_valid ? buf_head.pc + 64'd4 : '0;

`ifdef FETCH_CTRL_COMMIT_INFO_EN
  assign out_commit_info = {out_valid, out_instr, out_pre_pc, out_pc};
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed phases push expected requests/outputs, a monitor compares.
module tb_fetch_ctrl;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_pc, out_pre_pc;
  logic [31:0] out_instr;
`ifdef FETCH_CTRL_COMMIT_INFO_EN
  logic [160:0] out_commit_info;
`endif

  fetch_ctrl #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pre_pc(out_pre_pc)
`ifdef FETCH_CTRL_COMMIT_INFO_EN
    , .out_commit_info(out_commit_info)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_req = 0;
  int nexp = 0;
  int lat = 1;
  logic [63:0] exp_req[$];
  logic [63:0] exp_out[$];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_req(input logic [63:0] a);
    exp_req.push_back(a);
    nexp++;
  endtask

  task automatic wait_hs(input string nm);
    int t = 0;
    while (n_req < nexp && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_hs_timeout"}, 64'(n_req >= nexp), 64'd1);
    #1;
  endtask

  // Memory model: one response per accepted request, lat cycles later; cancelled by reset.
  initial begin : responder
    logic        hs;
    logic [63:0] paddr;
    int          cnt;
    cnt = 0;
    paddr = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = rst && imem_req_valid && imem_req_ready;
      if (hs) paddr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (!rst) cnt = 0;
      else begin
        if (hs) cnt = lat;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = instr_of(paddr);
          end
        end
      end
    end
  end

  // Monitor: every request handshake and every output pop is matched against the queues.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      if (imem_req_valid && imem_req_ready) begin
        n_req++;
        if (exp_req.size() == 0) chk("req_unexpected", imem_req_addr, 64'hDEAD);
        else begin
          e = exp_req.pop_front();
          chk("req_addr", imem_req_addr, e);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", out_pc, 64'hDEAD);
        else begin
          e = exp_out.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_instr", 64'(out_instr), 64'(instr_of(e)));
          chk("out_pre_pc", out_pre_pc, e + 64'd4);
`ifdef FETCH_CTRL_COMMIT_INFO_EN
          chk("commit_valid", 64'(out_commit_info[160]), 64'd1);
          chk("commit_pc", out_commit_info[63:0], e);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : main
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pre_pc", out_pre_pc, 64'd0);

    // Streaming from reset PC
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_req(RPC + 64'(4 * i));
      exp_out.push_back(RPC + 64'(4 * i));
    end
    wait_hs("stream");
    imem_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: buffer fills at two entries, first pop restarts fetch
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    expect_req(64'h8000_000C); exp_out.push_back(64'h8000_000C);
    expect_req(64'h8000_0010); exp_out.push_back(64'h8000_0010);
    wait_hs("fill");
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_head_pc", out_pc, 64'h8000_000C);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("prepop_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("postpop_req_valid", 64'(imem_req_valid), 64'd1);
    chk("postpop_req_addr", imem_req_addr, 64'h8000_0014);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Redirect during WAIT, response 3 cycles after issue is dropped
    lat = 3;
    imem_req_ready = 1'b1;
    expect_req(64'h8000_0014);
    wait_hs("wait_redir");
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1002;
    expect_req(64'h8000_1000); exp_out.push_back(64'h8000_1000);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("drain_out_valid0", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("drain_out_valid1", 64'(out_valid), 64'd0);
    chk("drain_req_valid", 64'(imem_req_valid), 64'd0);
    wait_hs("after_drain");
    imem_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Redirect coincident with response: no push
    lat = 1;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    expect_req(64'h8000_1004);
    wait_hs("redir_resp");
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_0000_2000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    expect_req(64'h2000);
    expect_req(64'h2004);
    @(negedge clk);
    chk("redir_resp_out_valid", 64'(out_valid), 64'd0);
    wait_hs("refill");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("refill_req_valid", 64'(imem_req_valid), 64'd0);
    chk("refill_head_pc", out_pc, 64'h2000);

    // Redirect in REQ with a full buffer flushes it; then PC wraps past 2^64
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    expect_req(64'hFFFF_FFFF_FFFF_FFFC); exp_out.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    expect_req(64'h0);                   exp_out.push_back(64'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    wait_hs("wrap");
    imem_req_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while a request is outstanding and the buffer holds an entry
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    expect_req(64'h4);
    expect_req(64'h8);
    wait_hs("pre_rst");
    rst = 1'b0;
    #1;
    chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_pc", out_pc, 64'd0);
    chk("midrst_out_instr", 64'(out_instr), 64'd0);
    chk("midrst_out_pre_pc", out_pre_pc, 64'd0);
`ifdef FETCH_CTRL_COMMIT_INFO_EN
    chk("midrst_commit", out_commit_info[63:0], 64'd0);
    chk("midrst_commit_valid", 64'(out_commit_info[160]), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    expect_req(RPC); exp_out.push_back(RPC);
    @(negedge clk);
    chk("rel_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rel_req_addr", imem_req_addr, RPC);
    wait_hs("post_rst");
    imem_req_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    chk("exp_req_left", 64'(exp_req.size()), 64'd0);
    chk("exp_out_left", 64'(exp_out.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, fetch buffer entries; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 redirect_valid  input  1  redirect fetch (branch/jump/trap).
REQ-006 redirect_pc  input  64  redirect target.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  64  request address.
REQ-010 imem_resp_valid  input  1  response valid; at most one per accepted request, any latency >= 1 cycle.
REQ-011 imem_resp_data  input  32  fetched instruction.
REQ-012 out_valid  output  1  buffer head valid toward decode.
REQ-013 out_ready  input  1  decode accepts head.
REQ-014 out_pc  output  64  head PC.
REQ-015 out_instr  output  32  head instruction.
REQ-016 out_pre_pc  output  64  head predicted next PC = out_pc + 4.
REQ-017 out_commit_info  output  161  {out_valid, out_instr, out_pre_pc, out_pc}; present only with FETCH_CTRL_COMMIT_INFO_EN.

Function
REQ-018 States: REQ (may issue), WAIT (one request outstanding), DRAIN (outstanding response to discard); at most one request outstanding.
REQ-019 REQ: imem_req_valid = (buffer count < BUF_DEPTH) && !redirect_valid; imem_req_addr = pc_q.
REQ-020 Request handshake (valid && ready): req_pc_q <= pc_q, pc_q <= pc_q + 4 (mod 2^64, wraps to 0), REQ -> WAIT.
REQ-021 WAIT, imem_resp_valid, no redirect: push {req_pc_q, imem_resp_data} to buffer tail; WAIT -> REQ; next request no earlier than following cycle.
REQ-022 Buffer slot reserved at issue; a response never arrives to a full buffer.
REQ-023 Response-to-out_valid latency exactly 1 cycle when buffer was empty; no combinational bypass.
REQ-024 Pop on out_valid && out_ready; simultaneous push and pop legal, count unchanged.
REQ-025 Redirect (any state) has priority: buffer flushed, out_valid 0 next cycle, pc_q <= {redirect_pc[63:2], 2'b00}.
REQ-026 Redirect in WAIT without same-cycle response: -> DRAIN; with same-cycle response: response discarded, -> REQ.
REQ-027 DRAIN: next imem_resp_valid discarded, -> REQ; redirect in DRAIN updates pc_q, stays DRAIN (or -> REQ if response same cycle).
REQ-028 Redirect in REQ: no request issued that cycle; fetch from new pc_q next cycle.
REQ-029 Outputs registered from buffer head; out_pc/out_instr hold stable while out_valid && !out_ready.
REQ-030 imem_resp_valid in REQ (protocol violation) ignored.

Reset
REQ-031 rst low: state REQ, pc_q = RESET_PC, req_pc_q = 0, buffer empty, out_valid 0, out_pc/out_instr/out_pre_pc 0, imem_req_valid 0 while asserted.
REQ-032 First request issued in first cycle after rst deasserts; reset mid-WAIT drops outstanding request, late response ignored until a new request is accepted.

Configuration
REQ-033 FETCH_CTRL_COMMIT_INFO_EN defined: out_commit_info port and logic present, bit 160 = out_valid.
REQ-034 Undefined: port absent, no extra logic; all other behaviour identical.

Structure
REQ-035 Package fetch_pkg: RESET_PC default, XLEN = 64, ILEN = 32, COMMIT_INFO_W = 161, typedef fetch_entry_t {pc[63:0], instr[31:0]}.
REQ-036 Sub-module fetch_buf: BUF_DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count.

Verification
REQ-037 Reset release, imem_req_ready=1, 1-cycle response, out_ready=1 -> requests 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pre_pc = out_pc + 4.
REQ-038 out_ready=0 -> exactly BUF_DEPTH (2) requests accepted, then imem_req_valid 0; first pop resumes requests next cycle.
REQ-039 Redirect to 0x8000_1002 during WAIT, response 3 cycles later -> response discarded, next request addr 0x8000_1000, buffer empty.
REQ-040 Redirect same cycle as response -> no push, out_valid 0, next request at redirect target.
REQ-041 pc_q = 0xFFFF_FFFF_FFFF_FFFC -> following request addr 0x0.
REQ-042 rst asserted while WAIT -> outputs zero immediately; after release request addr RESET_PC; with macro, out_commit_info[160] tracks out_valid.
